// File: rtl/ysyx_220053_muldiv_ctrl.sv
// RV64M multiply/divide sequencer: radix-2 shift-add multiplier and restoring divider.
// Latency: result N+1 cycles after accept (N=64, or 32 for W ops); div-by-zero and overflow take 1 cycle.
// Backpressure: stall_o holds the core while busy; ready_o only in IDLE; flush_i aborts at the next edge.
// Optional: define MULDIV_FASTMUL_EN for a single-cycle 64x64 array multiplier (division unchanged).
module ysyx_220053_muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      func3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [2:0]    func3_q, func3_d;
  logic          word_q, word_d;
  logic          neg_q, neg_d;
  logic [127:0]  prod_q, prod_d;
  logic [127:0]  mcand_q, mcand_d;
  logic [63:0]   mplier_q, mplier_d;
  logic [63:0]   rem_q, rem_d;
  logic [63:0]   quo_q, quo_d;
  logic [63:0]   dsor_q, dsor_d;
  logic [63:0]   result_q, result_d;

  // operand preparation on the incoming instruction
  logic          is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [63:0]   a_ext, b_ext, a_mag, b_mag;

  // result shaping from the datapath registers
  logic [63:0]   prod_hi_s, quo_s, rem_s, raw_res, final_res;

  // iteration step terms
  logic [64:0]   div_sh;

  // Extend W operands, then split signed operands into sign flag plus magnitude
  always_comb begin
    is_div   = func3_i[2];
    sgn_a    = (func3_i == 3'd1) || (func3_i == 3'd2) || (func3_i == 3'd4) || (func3_i == 3'd6);
    sgn_b    = (func3_i == 3'd1) || (func3_i == 3'd4) || (func3_i == 3'd6);
    a_ext    = word_i ? {{32{sgn_a & src1_i[31]}}, src1_i[31:0]} : src1_i;
    b_ext    = word_i ? {{32{sgn_b & src2_i[31]}}, src2_i[31:0]} : src2_i;
    a_neg    = sgn_a & a_ext[63];
    b_neg    = sgn_b & b_ext[63];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = is_div && (b_ext == 64'd0);
    div_ovf  = is_div && !func3_i[0] && (b_ext == '1) &&
               (a_ext == (word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

  // Restore signs and select the architectural result; the high half of -prod
  // is ~hi plus the carry out of negating the low half
  always_comb begin
    prod_hi_s = neg_q ? (~prod_q[127:64] + {63'd0, (prod_q[63:0] == 64'd0)}) : prod_q[127:64];
    quo_s     = neg_q ? -quo_q : quo_q;
    rem_s     = neg_q ? -rem_q : rem_q;
    case (func3_q)
      3'd0:       raw_res = prod_q[63:0];
      3'd1, 3'd2,
      3'd3:       raw_res = prod_hi_s;
      3'd4, 3'd5: raw_res = quo_s;
      default:    raw_res = rem_s;
    endcase
    final_res = word_q ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  // Next-state and datapath update: accept, iterate one bit per cycle, publish
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    word_d   = word_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsor_d   = dsor_q;
    result_d = result_q;
    div_sh   = {rem_q, quo_q[63]};

    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          func3_d = func3_i;
          word_d  = word_i;
          if (is_div) begin
            // quotient sign from both operands, remainder follows the dividend
            neg_d = func3_i[1] ? a_neg : (a_neg ^ b_neg);
            if (div_zero || div_ovf) begin
              // load the final quotient/remainder directly, no sign fix-up needed
              neg_d   = 1'b0;
              quo_d   = div_zero ? '1 : a_ext;
              rem_d   = div_zero ? a_ext : 64'd0;
              state_d = S_DONE;
            end else begin
              // W dividends start in the top half so the MSB-first walk sees them first
              rem_d   = 64'd0;
              quo_d   = word_i ? {a_mag[31:0], 32'd0} : a_mag;
              dsor_d  = b_mag;
              cnt_d   = word_i ? 6'd31 : 6'd63;
              state_d = S_DIV;
            end
          end else begin
            neg_d = a_neg ^ b_neg;
`ifdef MULDIV_FASTMUL_EN
            prod_d  = {64'd0, a_mag} * {64'd0, b_mag};
            state_d = S_DONE;
`else
            prod_d   = 128'd0;
            mcand_d  = {64'd0, a_mag};
            mplier_d = b_mag;
            cnt_d    = word_i ? 6'd31 : 6'd63;
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : 128'd0);
        mcand_d  = {mcand_q[126:0], 1'b0};
        mplier_d = {1'b0, mplier_q[63:1]};
        if (cnt_q == 6'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      S_DIV: begin
        if (div_sh >= {1'b0, dsor_q}) begin
          rem_d = div_sh[63:0] - dsor_q;
          quo_d = {quo_q[62:0], 1'b1};
        end else begin
          rem_d = div_sh[63:0];
          quo_d = {quo_q[62:0], 1'b0};
        end
        if (cnt_q == 6'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush_i) result_d = final_res;
      end
      default: state_d = S_IDLE;
    endcase

    // an abort wins over everything else
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      func3_q  <= 3'd0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      prod_q   <= 128'd0;
      mcand_q  <= 128'd0;
      mplier_q <= 64'd0;
      rem_q    <= 64'd0;
      quo_q    <= 64'd0;
      dsor_q   <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsor_q   <= dsor_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs; the result is live in DONE and held afterwards
  always_comb begin
    ready_o     = (state_q == S_IDLE);
    stall_o     = (state_q == S_MUL) || (state_q == S_DIV) || ((state_q == S_IDLE) && valid_i);
    out_valid_o = (state_q == S_DONE) && !flush_i;
    result_o    = (state_q == S_DONE) ? final_res : result_q;
  end

endmodule

// File: tb/tb_ysyx_220053_muldiv_ctrl.sv
// Self-checking bench for ysyx_220053_muldiv_ctrl: directed vector table, corner sequences
// (flush, reset mid-op, valid held through DONE) and random ops against an arithmetic model.
// Build with MULDIV_FASTMUL_EN defined to expect single-cycle multiplies.
module tb_ysyx_220053_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  func3_i = 3'd0;
  logic        word_i = 1'b0;
  logic [63:0] src1_i = 64'd0;
  logic [63:0] src2_i = 64'd0;
  logic        ready_o, stall_o, out_valid_o;
  logic [63:0] result_o;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FASTMUL_EN
  localparam bit FAST = 1'b1;
  localparam int ML64 = 1;
  localparam int ML32 = 1;
`else
  localparam bit FAST = 1'b0;
  localparam int ML64 = 65;
  localparam int ML32 = 33;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  ysyx_220053_muldiv_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .func3_i(func3_i), .word_i(word_i), .src1_i(src1_i), .src2_i(src2_i),
    .ready_o(ready_o), .stall_o(stall_o), .out_valid_o(out_valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    int          lat;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] r, input int lat, input string name);
    vec_t v;
    v.f = f; v.w = w; v.a = a; v.b = b; v.r = r; v.lat = lat; v.name = name;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic and the RISC-V corner-case rules
  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [31:0]  a32, b32, r32;
    int           sa32, sb32;
    longint       sa, sb;
    logic [63:0]  r;
    a32 = a[31:0]; b32 = b[31:0];
    sa32 = a32;    sb32 = b32;
    sa = a;        sb = b;
    r = 64'd0;
    r32 = 32'd0;
    if (w) begin
      case (f)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 32'd0) r32 = 32'hFFFF_FFFF;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else begin sa32 = sa32 / sb32; r32 = sa32; end
        end
        3'd5: r32 = (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 / b32;
        3'd6: begin
          if (b32 == 32'd0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'd0;
          else begin sa32 = sa32 % sb32; r32 = sa32; end
        end
        3'd7: r32 = (b32 == 32'd0) ? a32 : a32 % b32;
        default: r32 = 32'd0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      pa = {{64{a[63]}}, a};
      pb = {{64{b[63]}}, b};
      case (f)
        3'd0: r = a * b;
        3'd1: begin p = pa * pb; r = p[127:64]; end
        3'd2: begin p = pa * {64'd0, b}; r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        3'd4: begin
          if (b == 64'd0) r = ONES;
          else if (a == MIN && b == ONES) r = a;
          else begin sa = sa / sb; r = sa; end
        end
        3'd5: r = (b == 64'd0) ? ONES : a / b;
        3'd6: begin
          if (b == 64'd0) r = a;
          else if (a == MIN && b == ONES) r = 64'd0;
          else begin sa = sa % sb; r = sa; end
        end
        default: r = (b == 64'd0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  // Reference latency in cycles from the accept edge to the out_valid_o cycle
  function automatic int ref_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    int n;
    bit zero, ovf;
    n = w ? 33 : 65;
    if (!f[2]) return FAST ? 1 : n;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == MIN && b == ONES));
    return (zero || ovf) ? 1 : n;
  endfunction

  // Issue one op, follow it to completion and check latency, stall, result and hold
  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input int el, input string tag);
    int lat;
    bit stall_bad;
    lat = 0;
    stall_bad = 1'b0;
    @(negedge clk);
    func3_i = f; word_i = w; src1_i = a; src2_i = b; valid_i = 1'b1;
    #1;
    chk({tag, " accept"}, {62'd0, stall_o, ready_o}, 64'd3);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    src1_i = {$urandom, $urandom};
    src2_i = {$urandom, $urandom};
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(negedge clk);
      #1;
      if (out_valid_o) begin
        lat = i;
        chk({tag, " stall_done"}, {63'd0, stall_o}, 64'd0);
        chk({tag, " result"}, result_o, er);
      end else if (!stall_o) begin
        stall_bad = 1'b1;
      end
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " stall_busy"}, {63'd0, stall_bad}, 64'd0);
    if (lat != 0) begin
      @(negedge clk);
      #1;
      chk({tag, " idle_ready"}, {63'd0, ready_o}, 64'd1);
      chk({tag, " hold"}, result_o, er);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN;
      3: return 64'd1;
      4: return {$urandom, 32'h8000_0000};
      5: return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic        rw;
    logic [63:0] ra, rb;

    // directed vector table
    add(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, ML64, "mul_3x-5");
    add(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, ML64, "mulhu_ones");
    add(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML32, "mulw");
    add(3'd1, 1'b0, ONES, ONES, 64'd0, ML64, "mulh_m1");
    add(3'd1, 1'b0, MIN, MIN, 64'h4000_0000_0000_0000, ML64, "mulh_min");
    add(3'd2, 1'b0, ONES, 64'd2, ONES, ML64, "mulhsu");
    add(3'd4, 1'b0, 64'd7, 64'd0, ONES, 1, "div_by0");
    add(3'd6, 1'b0, MIN, ONES, 64'd0, 1, "rem_ovf");
    add(3'd4, 1'b0, MIN, ONES, MIN, 1, "div_ovf");
    add(3'd5, 1'b0, 64'd7, 64'd0, ONES, 1, "divu_by0");
    add(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw");
    add(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 33, "remw");
    add(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, "remu");
    add(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_neg");
    add(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_neg");
    add(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    add(3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "remw_ovf");
    add(3'd6, 1'b1, 64'd5, 64'h1234_5678_0000_0000, 64'd5, 1, "remw_by0");
    add(3'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'hFFFF_FFFF_9ABC_DEF0, 1, "remuw_by0");
    add(3'd4, 1'b1, 64'hAAAA_AAAA_0000_0007, 64'h5555_5555_0000_0000, ONES, 1, "divw_by0");
    add(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, ONES, 33, "divuw");

    // reset values
    #1;
    chk("rst ready", {63'd0, ready_o}, 64'd1);
    chk("rst stall", {63'd0, stall_o}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_op(vt[i].f, vt[i].w, vt[i].a, vt[i].b, vt[i].r, vt[i].lat, vt[i].name);

    // flush 10 cycles into a divide
    @(negedge clk);
    func3_i = 3'd4; word_i = 1'b0; src1_i = 64'd100; src2_i = 64'd3; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush busy stall", {63'd0, stall_o}, 64'd1);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    #1;
    chk("flush ready", {63'd0, ready_o}, 64'd1);
    chk("flush no valid", {63'd0, out_valid_o}, 64'd0);
    run_op(3'd5, 1'b0, 64'd100, 64'd10, 64'd10, 65, "divu_after_flush");

    // flush in DONE suppresses the pulse
    @(negedge clk);
    func3_i = 3'd4; word_i = 1'b0; src1_i = 64'd7; src2_i = 64'd0; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_done no valid", {63'd0, out_valid_o}, 64'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_done ready", {63'd0, ready_o}, 64'd1);

    // valid held high through DONE is ignored there, then re-accepted in IDLE
    @(negedge clk);
    func3_i = 3'd5; word_i = 1'b0; src1_i = 64'd9; src2_i = 64'd0; valid_i = 1'b1;
    @(negedge clk);
    #1;
    chk("hold_valid done pulse", {62'd0, out_valid_o, stall_o}, 64'd2);
    @(negedge clk);
    #1;
    chk("hold_valid idle again", {62'd0, ready_o, stall_o}, 64'd3);
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("hold_valid second pulse", {63'd0, out_valid_o}, 64'd1);
    @(negedge clk);

    // reset mid-operation
    run_op(3'd0, 1'b0, 64'd6, 64'd7, 64'd42, ML64, "mul_before_rst");
    @(negedge clk);
    func3_i = FAST ? 3'd5 : 3'd0; word_i = 1'b0; src1_i = 64'd100; src2_i = 64'd3; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {63'd0, ready_o}, 64'd1);
    chk("midrst stall", {63'd0, stall_o}, 64'd0);
    chk("midrst out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("midrst result", result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, ML64, "mul_after_rst");

    // random ops against the arithmetic model
    for (int n = 0; n < 150; n++) begin
      rf = 3'($urandom_range(0, 7));
      rw = (rf == 3'd1 || rf == 3'd2 || rf == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      run_op(rf, rw, ra, rb, ref_res(rf, rw, ra, rb), ref_lat(rf, rw, ra, rb), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
